// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// ----------------
// Collects 2^N asynchronous request lines into sticky pending bits. It presents
// the masked pending vector to a downstream priority encoder, takes the
// encoder's index back, and services one request at a time with an irq/ack
// handshake.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   reqIn     in   [2^N] asynchronous request lines, a 0->1 transition is one request
//   maskIn    in   [2^N] per-line enable (1 = line may be presented)
//   encIdx    in   [N]   index from the priority encoder, driven from pendOut
//   ack       in   service acknowledge from the consumer
//   clrOvr    in   synchronous clear of all overrun flags
//   pendOut   out  [2^N] pending & maskIn, drives the encoder input
//   irq       out  a captured request awaits ack
//   vecOut    out  [N]   index being serviced, stable while irq=1
//   overrun   out  [2^N] sticky per-line "request lost" flags
//   dbg_state out  [2]   current FSM state, for observation only
//
// Handshake: irq acts as valid and ack acts as ready. A service transfer
// happens on a rising clk edge where irq=1 and ack=1. irq then drops for at
// least two cycles (HOLD, then IDLE) before the next service can be offered.
// ack is ignored whenever irq=0.

module irq_pending_ctrl #(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(1<<N)-1:0]   reqIn,
    input  logic [(1<<N)-1:0]   maskIn,
    input  logic [N-1:0]        encIdx,
    input  logic                ack,
    input  logic                clrOvr,
    output logic [(1<<N)-1:0]   pendOut,
    output logic                irq,
    output logic [N-1:0]        vecOut,
    output logic [(1<<N)-1:0]   overrun,
    output logic [1:0]          dbg_state
);

    localparam int W = 1 << N;
    localparam logic [W-1:0] LINE0 = W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0] s1, s2, s3;
    logic [1:0]   warm_cnt;
    logic         warm;
    logic [W-1:0] rise;
    logic [W-1:0] pending, pend_nxt;
    logic [W-1:0] ovr_nxt, ovr_set;
    logic [W-1:0] svc_clr;
    logic         svc_take;
    logic         vec_load;

    // ------------------------------------------------------------------
    // Synchronizer and edge history.
    // For the first two edges after reset, s3 is loaded with the value that
    // s2 is about to receive. s2 and s3 therefore fill together, and a line
    // that is held high through reset never shows up as a rising edge.
    // ------------------------------------------------------------------
    assign warm = (warm_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            warm_cnt <= 2'd0;
        end else begin
            s1 <= reqIn;
            s2 <= s1;
            s3 <= warm ? s2 : s1;
            if (!warm) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign rise = s2 & ~s3;

    // ------------------------------------------------------------------
    // Pending and overrun bookkeeping.
    // A new edge on the line being cleared in the same cycle wins. It leaves
    // the bit pending and is not counted as lost.
    // ------------------------------------------------------------------
    assign svc_take = (state == REQ) && ack;
    assign svc_clr  = svc_take ? (LINE0 << vecOut) : '0;

    assign ovr_set  = rise & pending & ~svc_clr;
    assign pend_nxt = rise | (pending & ~svc_clr);
    assign ovr_nxt  = ovr_set | (clrOvr ? '0 : overrun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= pend_nxt;
            overrun <= ovr_nxt;
        end
    end

    assign pendOut = pending & maskIn;

    // ------------------------------------------------------------------
    // Service FSM.
    // encIdx is only sampled when pendOut is non-zero, so an undriven or X
    // index from an idle encoder never reaches vecOut.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_load  = 1'b0;
        case (state)
            IDLE: begin
                if (|pendOut) begin
                    vec_load  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // One quiet cycle lets pendOut and the encoder settle after the clear.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vecOut <= '0;
        end else if (vec_load) begin
            vecOut <= encIdx;
        end
    end

    // irq is decoded from the state register, so an asynchronous reset drops it at once.
    assign irq       = (state == REQ);
    assign dbg_state = state;

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Request-collection stage that sits directly upstream of the 2^N-to-N priority encoder. It synchronizes 2^N asynchronous request lines and rising-edge detects them into sticky pending bits. It presents the masked pending vector to the encoder's input and takes the encoder's N-bit index back. It then runs an irq/ack handshake that services one request at a time, highest index first, as resolved by the encoder.

## Interface
- N, default 2: encoder width; 2^N request lines, N-bit index.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- reqIn  input  2^N  asynchronous request lines; a 0→1 transition is one request.
- maskIn  input  2^N  per-line enable; 1 = line may be presented.
- encIdx  input  N  index from the downstream priority encoder, driven combinationally from pendOut.
- ack  input  1  service acknowledge from the consumer.
- clrOvr  input  1  synchronous clear of all overrun bits.
- pendOut  output  2^N  pending & maskIn; drives the encoder's sigIn.
- irq  output  1  a captured request awaits ack.
- vecOut  output  N  index being serviced; stable while irq=1.
- overrun  output  2^N  sticky per-line "request lost" flags.

## Operation
- Reset (rst_n=0, asynchronous): sync flops, edge-history flops, pending, overrun, vecOut = 0; state = IDLE; irq = 0; pendOut = 0.
- Synchronizer: a two-flop chain per line (s1, s2), plus a history flop s3.
  - edge[i] = s2[i] & ~s3[i].
- Pending register, updated per line every cycle:
  - A set is edge[i].
  - A clear is the service clear of line vecOut when ack is accepted.
  - Set and clear on the same line in the same cycle: set wins, pending stays 1, no overrun.
  - An edge while pending[i]=1 and not being cleared sets overrun[i]. pending stays 1; requests do not count.
- Masking: masked lines keep collecting pending bits but read 0 on pendOut. Unmasking a pending line presents it on the next cycle.
- pendOut = pending & maskIn, combinational from registers and maskIn.
- encIdx is ignored whenever pendOut = 0, including when it is X.
- FSM states IDLE, REQ, HOLD:
  - IDLE: irq=0. If |pendOut, capture vecOut ← encIdx and go to REQ. Otherwise stay.
  - REQ: irq=1, vecOut frozen. New or higher-priority arrivals do not change vecOut. Masking the line being served does not cancel the service.
    - On ack=1: clear pending[vecOut] and go to HOLD.
  - HOLD: irq=0 for one cycle so pendOut and encIdx settle, then go to IDLE.
- ack outside REQ is ignored. A held-high ack services at most one request per REQ entry.
- clrOvr=1 clears all overrun bits. An overrun set in the same cycle wins.
- All width arithmetic is unsigned. The index is N bits, with no wrap beyond 2^N-1.

## Timing
- reqIn rise sampled at edge k:
  - s1 at k, s2 at k+1, pending set at k+2.
  - pendOut high after k+2.
  - irq high after k+3, when the FSM is idle: 3-cycle latency.
- Ack accepted at edge j, where irq=1 and ack=1:
  - irq low and the pending bit cleared after j.
  - HOLD during j→j+1; IDLE at j+1.
  - Next irq high after j+2 at the earliest, giving a minimum 2 low cycles between services.
- vecOut changes only at an IDLE→REQ transition.
- overrun updates one cycle after the offending edge is detected.
- Reset asserted mid-handshake: irq drops immediately (asynchronous) and all pending requests are lost.
- After rst_n deasserts, a reqIn already high at reset is not a request: s3 powers up 0, but s2 and s3 fill together. Requirement: no edge is reported for a line held high through reset. Implement by reset-loading s3 via a s2==s3 compare, or equivalently by gating edge for 2 cycles after reset.

## Test plan
- Single request, N=2: pulse reqIn[2] 0→1 held high → pendOut=4'b0100 after 3 edges, irq=1 after 4, vecOut=2. ack for 1 cycle → irq=0, pendOut=0, irq stays 0.
- Priority and freeze: reqIn[1] rises; while irq=1 with vecOut=1, reqIn[3] rises → vecOut stays 1 until ack. After HOLD, irq reasserts with vecOut=3, then services 3 before any further request.
- Mask: mask line 3, raise reqIn[3] → pendOut=0, irq=0. Unmask → irq=1, vecOut=3 two cycles later.
- Overrun: reqIn[0] toggles 1→0→1 before ack → overrun=4'b0001, one service only. clrOvr → overrun=0.
- Simultaneous set/clear: a new edge on the served line in the ack cycle → pending stays 1, overrun stays 0, irq reasserts with the same vecOut after HOLD.
- Reset mid-REQ: rst_n low while irq=1 → irq, pendOut, vecOut, overrun = 0 immediately. A line held high across reset produces no request after release.
